// File: rtl/demux_stream_reg.sv
// demux_stream_reg: registered 1-to-NUM_OUT valid/ready stream demultiplexer.
// The selected channel gets a one-hot valid. Beats with an out-of-range select are dropped and counted.
//
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   in_valid/ready   input handshake
//   in_sel, in_data  destination channel and payload of the input beat
//   out_valid        one-hot (or zero) per-channel valid
//   out_ready        per-channel consumer ready
//   out_data         payload, shared by all channels
//   out_sel          index of the channel holding the register
//   drop_pulse       1-cycle pulse when an illegal-select beat is consumed
//   drop_cnt         saturating count of dropped beats
//   drop_clr         synchronous clear of drop_cnt
module demux_stream_reg #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [DATA_W-1:0]  in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               drop_pulse,
  output logic [CNT_W-1:0]   drop_cnt,
  input  logic               drop_clr
);

  // One extra bit so NUM_OUT == 2**SEL_W still fits.
  localparam logic [SEL_W:0] NUM_OUT_C = (SEL_W+1)'(NUM_OUT);

  logic [NUM_OUT-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_OUT-1:0] sel_dec;
  logic               full;
  logic               take;
  logic               fire;
  logic               legal;

  // valid_q is one-hot at sel_q, so masking with out_ready
  // picks out_ready[sel_q] without an out-of-range index.
  assign full     = |valid_q;
  assign take     = |(valid_q & out_ready);
  assign in_ready = ~rst & (~full | take);
  assign fire     = in_valid & in_ready;
  assign legal    = ({1'b0, in_sel} < NUM_OUT_C);

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_dec[i] = (in_sel == SEL_W'(i));
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    if (take) begin
      valid_d = '0;
    end
    if (fire && legal) begin
      valid_d = sel_dec;
      data_d  = in_data;
      sel_d   = in_sel;
    end
    if (fire && !legal) begin
      drop_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (drop_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_sel    = sel_q;
  assign drop_pulse = drop_q;
  assign drop_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_stream_reg.sv
// tb_demux_stream_reg: self-checking bench for demux_stream_reg.
// Instance a uses NUM_OUT=4 and instance b uses NUM_OUT=3, so that illegal selects exist.
module tb_demux_stream_reg;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [1:0] a_in_sel = '0;
  logic [7:0] a_in_data = '0;
  logic [3:0] a_out_valid;
  logic [3:0] a_out_ready = '0;
  logic [7:0] a_out_data;
  logic [1:0] a_out_sel;
  logic       a_drop_pulse;
  logic [7:0] a_drop_cnt;
  logic       a_drop_clr = 1'b0;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [1:0] b_in_sel = '0;
  logic [7:0] b_in_data = '0;
  logic [2:0] b_out_valid;
  logic [2:0] b_out_ready = '0;
  logic [7:0] b_out_data;
  logic [1:0] b_out_sel;
  logic       b_drop_pulse;
  logic [7:0] b_drop_cnt;
  logic       b_drop_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  beat_t q[$];
  int    drops = 0;

  always #5 clk = ~clk;

  demux_stream_reg #(
    .DATA_W(8), .SEL_W(2), .NUM_OUT(4), .CNT_W(8)
  ) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sel(a_out_sel),
    .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt),
    .drop_clr(a_drop_clr)
  );

  demux_stream_reg #(
    .DATA_W(8), .SEL_W(2), .NUM_OUT(3), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sel(b_out_sel),
    .drop_pulse(b_drop_pulse), .drop_cnt(b_drop_cnt),
    .drop_clr(b_drop_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (a_out_valid !== 4'b0 || a_out_data !== 8'h0 ||
        a_out_sel !== 2'd0 || a_drop_pulse !== 1'b0 ||
        a_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rst_init: v=%b d=%h s=%0d p=%b c=%0d want 0",
               a_out_valid, a_out_data, a_out_sel,
               a_drop_pulse, a_drop_cnt);
    end
    a_out_ready = 4'hF;
    #1;
    tests++;
    if (a_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_ready: got %b want 0", a_in_ready);
    end
    tick();
    rst = 1'b0;
    a_out_ready = 4'h0;
    // b: one dropped beat, then a held legal beat
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h99;
    tick();
    b_in_sel = 2'd0; b_in_data = 8'h77; b_out_ready = 3'b0;
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h33;
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    tests++;
    if (a_out_valid !== 4'b0010 || b_drop_cnt !== 8'd1 ||
        b_out_valid !== 3'b001) begin
      fails++;
      $display("FAIL pre_rst: av=%b bc=%0d bv=%b want 0010 1 001",
               a_out_valid, b_drop_cnt, b_out_valid);
    end
    a_out_ready = 4'hF; b_out_ready = 3'h7;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (a_out_valid !== 4'b0 || b_out_valid !== 3'b0 ||
        b_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL async_rst: av=%b bv=%b bc=%0d want 0",
               a_out_valid, b_out_valid, b_drop_cnt);
    end
    tests++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready: a=%b b=%b want 0",
               a_in_ready, b_in_ready);
    end
    tick();
    rst = 1'b0;
    a_out_ready = 4'h0; b_out_ready = 3'h0;
    tick();
    tick();
    tests++;
    if (a_out_valid !== 4'b0 || b_out_valid !== 3'b0 ||
        a_out_data !== 8'h0 || a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_rst: av=%b bv=%b d=%h rdy=%b want 0 0 0 1",
               a_out_valid, b_out_valid, a_out_data, a_in_ready);
    end
  endtask

  task automatic test_stream();
    a_out_ready = 4'hF;
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_sel  = 2'(i);
      a_in_data = 8'hA0 + 8'(i);
      #1;
      tests++;
      if (a_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_rdy%0d: got %b want 1", i, a_in_ready);
      end
      tick();
      tests++;
      if (a_out_valid !== (4'd1 << i) ||
          a_out_data !== 8'hA0 + 8'(i)) begin
        fails++;
        $display("FAIL stream%0d: v=%b d=%h want %b %h", i,
                 a_out_valid, a_out_data, 4'd1 << i, 8'hA0 + 8'(i));
      end
    end
    a_in_valid = 1'b0;
    tick();
    tests++;
    if (a_out_valid !== 4'b0) begin
      fails++;
      $display("FAIL stream_drain: v=%b want 0000", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 4'b0001;
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'h5C;
    tick();
    a_in_sel = 2'd1; a_in_data = 8'h11;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (a_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_rdy%0d: got %b want 0", i, a_in_ready);
      end
      tick();
      tests++;
      if (a_out_valid !== 4'b0100 || a_out_data !== 8'h5C ||
          a_out_sel !== 2'd2) begin
        fails++;
        $display("FAIL bp_hold%0d: v=%b d=%h s=%0d want 0100 5c 2",
                 i, a_out_valid, a_out_data, a_out_sel);
      end
    end
    a_out_ready = 4'b0100;
    #1;
    tests++;
    if (a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got %b want 1", a_in_ready);
    end
    tick();
    tests++;
    if (a_out_valid !== 4'b0010 || a_out_data !== 8'h11) begin
      fails++;
      $display("FAIL bp_next: v=%b d=%h want 0010 11",
               a_out_valid, a_out_data);
    end
    a_in_valid = 1'b0; a_out_ready = 4'hF;
    tick();
  endtask

  task automatic test_illegal();
    b_out_ready = 3'h7;
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'($urandom);
    tick();
    b_in_valid = 1'b0;
    tests++;
    if (b_out_valid !== 3'b0 || b_drop_pulse !== 1'b1 ||
        b_drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL ill_one: v=%b p=%b c=%0d want 000 1 1",
               b_out_valid, b_drop_pulse, b_drop_cnt);
    end
    tick();
    tests++;
    if (b_drop_pulse !== 1'b0 || b_drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL ill_after: p=%b c=%0d want 0 1",
               b_drop_pulse, b_drop_cnt);
    end
    b_in_valid = 1'b1;
    repeat (300) begin
      b_in_data = 8'($urandom);
      tick();
    end
    b_in_valid = 1'b0;
    tick();
    tests++;
    if (b_drop_cnt !== 8'd255 || b_out_valid !== 3'b0) begin
      fails++;
      $display("FAIL ill_sat: c=%0d v=%b want 255 000",
               b_drop_cnt, b_out_valid);
    end
  endtask

  task automatic test_clear();
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_drop_clr = 1'b1;
    tick();
    b_in_valid = 1'b0; b_drop_clr = 1'b0;
    tests++;
    if (b_drop_cnt !== 8'd0 || b_drop_pulse !== 1'b1) begin
      fails++;
      $display("FAIL clr_collide: c=%0d p=%b want 0 1",
               b_drop_cnt, b_drop_pulse);
    end
    tick();
    tests++;
    if (b_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL clr_hold: c=%0d want 0", b_drop_cnt);
    end
  endtask

  // Reference: the queue holds accepted legal beats not yet delivered.
  // The DUT buffers one beat, so q[0] is the beat the outputs must show.
  task automatic rand_cycle(input logic iv, input logic [1:0] s,
                            input logic [7:0] d, input logic [2:0] r);
    beat_t      b;
    logic       exp_rdy;
    logic [2:0] exp_v;
    logic       exp_p;
    int         exp_c;
    b_in_valid = iv; b_in_sel = s; b_in_data = d; b_out_ready = r;
    #1;
    exp_v = 3'b0;
    exp_rdy = 1'b1;
    if (q.size() != 0) begin
      exp_v = 3'd1 << q[0].sel;
      exp_rdy = r[q[0].sel];
    end
    tests++;
    if (b_out_valid !== exp_v) begin
      fails++;
      $display("FAIL rnd_valid: got %b want %b", b_out_valid, exp_v);
    end
    tests++;
    if (b_in_ready !== exp_rdy) begin
      fails++;
      $display("FAIL rnd_ready: got %b want %b", b_in_ready, exp_rdy);
    end
    if (|(b_out_valid & r)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL rnd_dup: beat s=%0d d=%h delivered, none due",
                 b_out_sel, b_out_data);
      end else begin
        b = q.pop_front();
        if (b_out_sel !== b.sel || b_out_data !== b.data) begin
          fails++;
          $display("FAIL rnd_beat: got s=%0d d=%h want s=%0d d=%h",
                   b_out_sel, b_out_data, b.sel, b.data);
        end
      end
    end
    exp_p = 1'b0;
    if (iv && exp_rdy) begin
      if (s < 2'd3) begin
        b.sel = s; b.data = d;
        q.push_back(b);
      end else begin
        drops++;
        exp_p = 1'b1;
      end
    end
    tick();
    exp_c = (drops > 255) ? 255 : drops;
    tests++;
    if (b_drop_pulse !== exp_p || int'(b_drop_cnt) != exp_c) begin
      fails++;
      $display("FAIL rnd_drop: p=%b c=%0d want %b %0d",
               b_drop_pulse, b_drop_cnt, exp_p, exp_c);
    end
  endtask

  task automatic test_random();
    q.delete();
    drops = 0;
    b_in_valid = 1'b0;
    b_out_ready = 3'h7;
    b_drop_clr = 1'b1;
    tick();
    b_drop_clr = 1'b0;
    tick();
    for (int i = 0; i < 3000; i++) begin
      rand_cycle(($urandom % 4) != 0, 2'($urandom),
                 8'($urandom), 3'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      rand_cycle(1'b0, 2'd0, 8'h0, 3'h7);
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL rnd_lost: %0d beats undelivered want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_illegal();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
